// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmit path (dintx/newd/donetx) among NUM_REQ byte producers.
// Latency: grant and newd one cycle after a request is seen idle; ack one cycle after donetx rises (or after LOAD if it rose early).
// Backpressure: requesters hold req/req_data until ack or err; a watchdog aborts a stuck frame so others are not locked out.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int NEWD_HOLD      = 256,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         err,
  output logic                       busy,
  output logic [7:0]                 uart_dintx,
  output logic                       uart_newd,
  input  logic                       uart_donetx
);

  localparam int IDW = $clog2(NUM_REQ);
  // Counter only has to reach TIMEOUT_CYCLES; NEWD_HOLD is always smaller.
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  HOLD_LAST = CW'(NEWD_HOLD - 1);
  localparam logic [CW-1:0]  TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t               state, state_nxt;
  logic [IDW-1:0]       rr_ptr, rr_ptr_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 done_prev;
  logic                 done_seen, done_seen_nxt;
  logic                 done_rise;

  logic [NUM_REQ-1:0]   grant_nxt;
  logic [IDW-1:0]       active_id_nxt;
  logic [NUM_REQ-1:0]   ack_nxt;
  logic [NUM_REQ-1:0]   err_nxt;
  logic                 busy_nxt;
  logic [7:0]           dintx_nxt;
  logic                 newd_nxt;

  // arbitration results
  logic                 pick_vld;
  logic [IDW-1:0]       pick_idx;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [7:0]           pick_byte;
  logic [IDW-1:0]       rr_after;
  int                   cand;
  logic [IDW-1:0]       cand_idx;

  // donetx is treated as a level from the baud domain; only its rising edge completes a frame
  assign done_rise = uart_donetx & ~done_prev;

  // next round-robin start: one past the requester just finished, wrapping at NUM_REQ
  assign rr_after = (active_id == LAST_ID) ? '0 : active_id + 1'b1;

  // search rr_ptr, rr_ptr+1, ... (mod NUM_REQ); walking backwards lets the closest hit win
  always_comb begin
    pick_vld  = 1'b0;
    pick_idx  = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDW'(cand);
      if (req[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  // one-hot grant vector and byte mux for the chosen requester
  always_comb begin
    pick_oh   = '0;
    pick_byte = '0;
    if (pick_vld) begin
      pick_oh[pick_idx] = 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDW'(i)) begin
        pick_byte = req_data[8*i +: 8];
      end
    end
  end

  // next-state and next-output logic; every output is registered from these
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    cnt_nxt       = cnt;
    done_seen_nxt = done_seen;
    grant_nxt     = grant;
    active_id_nxt = active_id;
    ack_nxt       = '0;
    err_nxt       = '0;
    busy_nxt      = busy;
    dintx_nxt     = uart_dintx;
    newd_nxt      = uart_newd;

    unique case (state)
      S_IDLE: begin
        if (pick_vld) begin
          state_nxt     = S_LOAD;
          grant_nxt     = pick_oh;
          active_id_nxt = pick_idx;
          busy_nxt      = 1'b1;
          dintx_nxt     = pick_byte;
          newd_nxt      = 1'b1;
          cnt_nxt       = '0;
          done_seen_nxt = 1'b0;
        end
      end

      S_LOAD: begin
        cnt_nxt = cnt + 1'b1;
        // a fast transmitter may finish before newd is released; remember it
        if (done_rise) begin
          done_seen_nxt = 1'b1;
        end
        if (cnt == TMO_LAST) begin
          state_nxt = S_ERR;
          err_nxt   = grant;
          newd_nxt  = 1'b0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = S_WAIT;
          newd_nxt  = 1'b0;
        end
      end

      S_WAIT: begin
        cnt_nxt = cnt + 1'b1;
        // completion wins over a timeout landing on the same cycle
        if (done_rise || done_seen) begin
          state_nxt = S_DONE;
          ack_nxt   = grant;
        end else if (cnt == TMO_LAST) begin
          state_nxt = S_ERR;
          err_nxt   = grant;
          newd_nxt  = 1'b0;
        end
      end

      S_DONE, S_ERR: begin
        state_nxt     = S_IDLE;
        rr_ptr_nxt    = rr_after;
        grant_nxt     = '0;
        active_id_nxt = '0;
        busy_nxt      = 1'b0;
        newd_nxt      = 1'b0;
        cnt_nxt       = '0;
        done_seen_nxt = 1'b0;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // state and output registers; synchronous active-low reset drops everything at once
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      cnt        <= '0;
      done_prev  <= 1'b0;
      done_seen  <= 1'b0;
      grant      <= '0;
      active_id  <= '0;
      ack        <= '0;
      err        <= '0;
      busy       <= 1'b0;
      uart_dintx <= '0;
      uart_newd  <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      cnt        <= cnt_nxt;
      done_prev  <= uart_donetx;
      done_seen  <= done_seen_nxt;
      grant      <= grant_nxt;
      active_id  <= active_id_nxt;
      ack        <= ack_nxt;
      err        <= err_nxt;
      busy       <= busy_nxt;
      uart_dintx <= dintx_nxt;
      uart_newd  <= newd_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART transmitter model.
// Latency: expectations are in cycles counted from the first sample showing the grant.
// Backpressure: the model answers each newd rise with a donetx pulse unless suppressed.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [1:0]  active_id;
  logic [3:0]  ack;
  logic [3:0]  err;
  logic        busy;
  logic [7:0]  uart_dintx;
  logic        uart_newd;
  logic        uart_donetx = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // transmitter model controls and state
  bit no_done    = 1'b0;
  int done_delay = 20;
  bit newd_q     = 1'b0;
  bit pend       = 1'b0;
  int cd         = 0;
  int hi         = 0;

  // results of run_out
  bit         r_ok;
  int         r_newd, r_acks, r_errs, r_ack_at, r_err_at, r_done_at;
  logic [3:0] r_ack_v, r_err_v;
  logic       r_err_newd;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .NEWD_HOLD(4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .grant(grant),
    .active_id(active_id),
    .ack(ack),
    .err(err),
    .busy(busy),
    .uart_dintx(uart_dintx),
    .uart_newd(uart_newd),
    .uart_donetx(uart_donetx)
  );

  // UART model: donetx goes high done_delay cycles after newd rises, for two cycles
  always @(negedge clk) begin
    if (!rst) begin
      pend = 1'b0; cd = 0; hi = 0; newd_q = 1'b0; uart_donetx = 1'b0;
    end else begin
      if (hi > 0) begin
        hi = hi - 1;
        if (hi == 0) uart_donetx = 1'b0;
      end
      if (pend) begin
        if (cd <= 1) begin pend = 1'b0; uart_donetx = 1'b1; hi = 2; end
        else cd = cd - 1;
      end
      if (uart_newd && !newd_q && !no_done) begin pend = 1'b1; cd = done_delay; end
      newd_q = uart_newd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (grant != 4'b0000) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // follow the current transfer until grant drops, recording what happened
  task automatic run_out(input int limit);
    int n = 0;
    r_ok = 1'b0; r_newd = 0; r_acks = 0; r_errs = 0;
    r_ack_at = -1; r_err_at = -1; r_done_at = -1;
    r_ack_v = 4'b0000; r_err_v = 4'b0000; r_err_newd = 1'b1;
    while (n < limit) begin
      if (grant == 4'b0000) begin r_ok = 1'b1; break; end
      if (uart_newd) r_newd++;
      if (uart_donetx && r_done_at < 0) r_done_at = n;
      if (ack != 4'b0000) begin r_acks++; r_ack_v = ack; r_ack_at = n; end
      if (err != 4'b0000) begin r_errs++; r_err_v = err; r_err_at = n; r_err_newd = uart_newd; end
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b0000; req_data = 32'h0;
    repeat (3) tick();
    n_cmp++; if ({grant, active_id, ack, err, busy, uart_dintx, uart_newd} !== 24'h0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", {grant, active_id, ack, err, busy, uart_dintx, uart_newd}); end
    rst = 1'b1;
    tick();
    n_cmp++; if ({grant, busy, uart_newd} !== 6'b0) begin n_bad++; $display("FAIL idle_no_req: got %b want 0", {grant, busy, uart_newd}); end
  endtask

  task automatic test_single();
    bit ok;
    req_data = 32'h00A50000; req = 4'b0100;
    wait_grant(10, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL single_grant_seen: got %b want 1", ok); end
    n_cmp++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL single_grant: got %b want 0100", grant); end
    n_cmp++; if (active_id !== 2'd2) begin n_bad++; $display("FAIL single_active_id: got %0d want 2", active_id); end
    n_cmp++; if (uart_dintx !== 8'hA5) begin n_bad++; $display("FAIL single_dintx: got %h want a5", uart_dintx); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
    req = 4'b0000;
    run_out(200);
    n_cmp++; if (r_ok !== 1'b1) begin n_bad++; $display("FAIL single_drain: got %b want 1", r_ok); end
    n_cmp++; if (r_newd != 4) begin n_bad++; $display("FAIL single_newd_len: got %0d want 4", r_newd); end
    n_cmp++; if (r_acks != 1 || r_ack_v !== 4'b0100) begin n_bad++; $display("FAIL single_ack: got %0d x %b want 1 x 0100", r_acks, r_ack_v); end
    n_cmp++; if (r_ack_at != r_done_at || r_ack_at != 21) begin n_bad++; $display("FAIL single_ack_time: got ack@%0d done@%0d want 21", r_ack_at, r_done_at); end
    n_cmp++; if (r_errs != 0) begin n_bad++; $display("FAIL single_no_err: got %0d want 0", r_errs); end
    n_cmp++; if ({busy, grant} !== 5'b0) begin n_bad++; $display("FAIL single_after_busy: got %b want 0", {busy, grant}); end
    n_cmp++; if (uart_dintx !== 8'hA5) begin n_bad++; $display("FAIL single_dintx_hold: got %h want a5", uart_dintx); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] exp_b [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    logic [3:0] exp_oh;
    req_data = 32'h44332211;
    rst = 1'b0; tick(); rst = 1'b1;
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_oh = 4'b0001 << (t % 4);
      wait_grant(10, ok);
      n_cmp++; if (ok !== 1'b1 || grant !== exp_oh) begin n_bad++; $display("FAIL b2b_grant[%0d]: got %b want %b", t, grant, exp_oh); end
      n_cmp++; if (uart_dintx !== exp_b[t]) begin n_bad++; $display("FAIL b2b_byte[%0d]: got %h want %h", t, uart_dintx, exp_b[t]); end
      if (t == 4) req = 4'b0000;
      run_out(200);
      n_cmp++; if (r_acks != 1 || r_ack_v !== exp_oh) begin n_bad++; $display("FAIL b2b_ack[%0d]: got %0d x %b want 1 x %b", t, r_acks, r_ack_v, exp_oh); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    req = 4'b1000;
    wait_grant(10, ok);
    n_cmp++; if (ok !== 1'b1 || grant !== 4'b1000) begin n_bad++; $display("FAIL wrap_first: got %b want 1000", grant); end
    req = 4'b1001;
    run_out(200);
    wait_grant(10, ok);
    n_cmp++; if (ok !== 1'b1 || grant !== 4'b0001) begin n_bad++; $display("FAIL wrap_zero_first: got %b want 0001", grant); end
    n_cmp++; if (uart_dintx !== 8'h11) begin n_bad++; $display("FAIL wrap_byte: got %h want 11", uart_dintx); end
    req = 4'b1000;
    run_out(200);
    wait_grant(10, ok);
    n_cmp++; if (ok !== 1'b1 || grant !== 4'b1000) begin n_bad++; $display("FAIL wrap_three_next: got %b want 1000", grant); end
    req = 4'b0000;
    run_out(200);
    n_cmp++; if (r_acks != 1 || r_ack_v !== 4'b1000) begin n_bad++; $display("FAIL wrap_ack: got %0d x %b want 1 x 1000", r_acks, r_ack_v); end
  endtask

  task automatic test_timeout();
    bit ok;
    req_data = 32'h44C35A11;
    no_done = 1'b1;
    req = 4'b0110;
    wait_grant(10, ok);
    n_cmp++; if (ok !== 1'b1 || grant !== 4'b0010) begin n_bad++; $display("FAIL tmo_grant: got %b want 0010", grant); end
    n_cmp++; if (uart_dintx !== 8'h5A) begin n_bad++; $display("FAIL tmo_byte: got %h want 5a", uart_dintx); end
    req = 4'b0100;
    run_out(200);
    no_done = 1'b0;
    n_cmp++; if (r_errs != 1 || r_err_v !== 4'b0010) begin n_bad++; $display("FAIL tmo_err: got %0d x %b want 1 x 0010", r_errs, r_err_v); end
    n_cmp++; if (r_err_at != 64) begin n_bad++; $display("FAIL tmo_err_time: got %0d want 64", r_err_at); end
    n_cmp++; if (r_acks != 0) begin n_bad++; $display("FAIL tmo_no_ack: got %0d want 0", r_acks); end
    n_cmp++; if (r_err_newd !== 1'b0) begin n_bad++; $display("FAIL tmo_newd_low: got %b want 0", r_err_newd); end
    wait_grant(10, ok);
    n_cmp++; if (ok !== 1'b1 || grant !== 4'b0100) begin n_bad++; $display("FAIL tmo_next_grant: got %b want 0100", grant); end
    n_cmp++; if (uart_dintx !== 8'hC3) begin n_bad++; $display("FAIL tmo_next_byte: got %h want c3", uart_dintx); end
    req = 4'b0000;
    run_out(200);
    n_cmp++; if (r_acks != 1 || r_ack_v !== 4'b0100) begin n_bad++; $display("FAIL tmo_next_ack: got %0d x %b want 1 x 0100", r_acks, r_ack_v); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    req_data = 32'h99C35A77;
    req = 4'b1001;
    wait_grant(10, ok);
    n_cmp++; if (ok !== 1'b1 || grant !== 4'b1000) begin n_bad++; $display("FAIL rst_pre_grant: got %b want 1000", grant); end
    for (int i = 0; i < 20; i++) begin
      if (!uart_newd) break;
      tick();
    end
    n_cmp++; if (uart_newd !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL rst_reach_wait: got newd=%b busy=%b want 0 1", uart_newd, busy); end
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++; if ({grant, active_id, ack, err, busy, uart_dintx, uart_newd} !== 24'h0) begin n_bad++; $display("FAIL rst_mid_outputs: got %h want 0", {grant, active_id, ack, err, busy, uart_dintx, uart_newd}); end
    rst = 1'b1;
    tick();
    n_cmp++; if (grant !== 4'b0001 || uart_dintx !== 8'h77) begin n_bad++; $display("FAIL rst_rearb: got %b/%h want 0001/77", grant, uart_dintx); end
    n_cmp++; if ({ack, err} !== 8'h0) begin n_bad++; $display("FAIL rst_no_pulse: got %b want 0", {ack, err}); end
    req = 4'b0000;
    run_out(200);
    n_cmp++; if (r_acks != 1 || r_ack_v !== 4'b0001 || r_errs != 0) begin n_bad++; $display("FAIL rst_after_ack: got %0d x %b err %0d want 1 x 0001 err 0", r_acks, r_ack_v, r_errs); end
  endtask

  task automatic test_done_in_load();
    bit ok;
    req_data = 32'h99C33C77;
    done_delay = 2;
    req = 4'b0010;
    wait_grant(10, ok);
    n_cmp++; if (ok !== 1'b1 || grant !== 4'b0010 || uart_dintx !== 8'h3C) begin n_bad++; $display("FAIL load_grant: got %b/%h want 0010/3c", grant, uart_dintx); end
    req = 4'b0000;
    run_out(200);
    done_delay = 20;
    n_cmp++; if (r_acks != 1 || r_ack_v !== 4'b0010) begin n_bad++; $display("FAIL load_ack: got %0d x %b want 1 x 0010", r_acks, r_ack_v); end
    n_cmp++; if (r_ack_at != 5) begin n_bad++; $display("FAIL load_ack_time: got %0d want 5", r_ack_at); end
    n_cmp++; if (r_errs != 0 || r_newd != 4) begin n_bad++; $display("FAIL load_no_err: got err %0d newd %0d want 0 4", r_errs, r_newd); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_done_in_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running want finished");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single transmit path of the UART top (dintx/newd/donetx) among NUM_REQ byte producers. Round-robin arbitration picks one requester, loads its byte, and holds newd long enough for the slow baud-domain transmitter to sample it. It then waits for the donetx rising edge and acknowledges the requester. A watchdog aborts a transfer that never completes, so one stuck frame cannot lock out the other requesters.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NEWD_HOLD, 256, clk cycles uart_newd stays high per transfer (≥ one baud-tick period of the transmitter)
TIMEOUT_CYCLES, 8192, max clk cycles from grant to donetx rise before abort

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  reset; synchronous, active-low (0 = reset)
req  in  NUM_REQ  level request per requester; req_data must be stable while high
req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i]
grant  out  NUM_REQ  one-hot, the requester being served
active_id  out  $clog2(NUM_REQ)  index of granted requester (0 when idle)
ack  out  NUM_REQ  one-cycle pulse, byte transmitted
err  out  NUM_REQ  one-cycle pulse, transfer timed out
busy  out  1  high from grant through completion
uart_dintx  out  8  byte to UART transmitter
uart_newd  out  1  start request to UART transmitter
uart_donetx  in  1  UART transmit done

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0, state IDLE, rr_ptr=0, counters 0, done_prev=0. Reset mid-transfer aborts immediately with no ack/err; newd drops in the next cycle.
- All outputs registered. Internal done_rise = uart_donetx & ~done_prev, where done_prev is registered every cycle.
- IDLE: if any req, select the first asserted index searching rr_ptr, rr_ptr+1, … modulo NUM_REQ. At the next edge: grant one-hot, active_id=i, busy=1, uart_dintx=req_data[i], uart_newd=1, cnt=0, state LOAD. With no req, stay in IDLE with all outputs at 0.
- LOAD: uart_newd=1 for exactly NEWD_HOLD cycles, then uart_newd=0 and state WAIT. A done_rise seen during LOAD sets a sticky done_seen flag.
- WAIT: on done_rise or done_seen, go to DONE.
- DONE (one cycle): ack[i]=1; grant, busy and active_id clear the next cycle; rr_ptr=(i+1) mod NUM_REQ; state IDLE. The earliest next grant is the cycle after DONE.
- Watchdog: cnt increments every cycle in LOAD and WAIT. When cnt reaches TIMEOUT_CYCLES without completion, go to ERR. ERR pulses err[i] for one cycle (no ack), forces newd=0, advances rr_ptr as in DONE, and returns to IDLE. TIMEOUT_CYCLES ≤ NEWD_HOLD is illegal.
- uart_dintx holds its value after the transfer until the next grant.
- If req[i] drops mid-transfer, the transfer still completes and is acked. If req[i] is still high after ack, it is re-eligible at the lowest priority of the rotation.
- Simultaneous requests always resolve by rr_ptr order. With every req held high, requesters are served in order 0,1,…,NUM_REQ-1,0,…

Test Plan:
(Benches override NEWD_HOLD=4, TIMEOUT_CYCLES=64, NUM_REQ=4; UART model pulses donetx 20 cycles after newd rises.)
- req[2]=1 with data 0xA5 -> grant=4'b0100, uart_dintx=0xA5, newd high exactly 4 cycles, ack[2] one cycle after the donetx rise, busy low afterwards.
- req=4'b1111 held, data 0x11/0x22/0x33/0x44 -> bytes sent in order 0x11,0x22,0x33,0x44,0x11; exactly one ack per transfer.
- After serving req 3, req=4'b1001 -> rr_ptr wraps to 0, so 0 is granted before 3.
- donetx never pulses for req[1] -> err[1] pulses at grant+64 cycles, no ack, then req[2] (pending) is granted next.
- rst=0 for one cycle during WAIT -> all outputs 0 the next cycle, no ack/err; after release, the pending req is re-arbitrated from index 0.
- donetx rises during LOAD (model delay 2) -> done_seen is captured and ack follows immediately after LOAD ends, with no hang and no timeout.
